mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one multi-cycle signed multiplier (`mul`: start/done handshake, WIDTH-bit operands, 2*WIDTH-bit product) between NUM_REQ requesters. It captures a requester's operands, drives the multiplier's start pulse, waits for done, and returns the product to the granted requester. It sits between the accelerator's compute clients and the single `mul` instance.

---
 rtl/mul_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mul_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle signed multiplier among NUM_REQ clients.
// Optional WAIT watchdog enabled by defining MUL_ARB_TIMEOUT_EN.
module mul_arbiter #(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [NUM_REQ-1:0]         resp_valid,
    output logic [NUM_REQ-1:0]         resp_err,
    output logic [2*WIDTH-1:0]         resp_product,
    output logic                       busy,
    output logic                       mul_start,
    output logic [WIDTH-1:0]           mul_a,
    output logic [WIDTH-1:0]           mul_b,
    input  logic [2*WIDTH-1:0]         mul_product,
    input  logic                       mul_done
);

    localparam int unsigned IDXW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait,
        StResp
    } state_e;

    state_e r_state, w_state_d;

    logic [IDXW-1:0]    r_ptr, r_idx, w_sel, w_ptr_next;
    logic               w_found, w_grant, w_timeout, w_tmo_hit;
    logic [WIDTH-1:0]   w_sel_a, w_sel_b;
    logic [NUM_REQ-1:0] w_sel_onehot, w_idx_onehot;

    logic [NUM_REQ-1:0] r_req_ack, r_resp_valid, r_resp_err;
    logic [2*WIDTH-1:0] r_resp_product;
    logic               r_busy, r_mul_start;
    logic [WIDTH-1:0]   r_mul_a, r_mul_b;

    // First requester at or after the rotation pointer, wrapping.
    always_comb begin
        int unsigned j;
        j       = 0;
        w_sel   = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = 32'(r_ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!w_found && req_valid[IDXW'(j)]) begin
                w_found = 1'b1;
                w_sel   = IDXW'(j);
            end
        end
    end

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_sel == IDXW'(i)) begin
                w_sel_a = req_a[i*WIDTH +: WIDTH];
                w_sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_sel_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel;
    assign w_idx_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_idx;
    assign w_ptr_next   = (r_idx == IDXW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TmoW-1:0] r_tmo_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (r_state == StStart) begin
            r_tmo_cnt <= '0;
        end else if (r_state == StWait) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Fires on the TIMEOUT_CYCLES-th edge spent in WAIT.
    assign w_tmo_hit = (r_state == StWait) && (r_tmo_cnt == TmoW'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
    assign w_tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_grant   = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_grant   = 1'b1;
                    w_state_d = StStart;
                end
            end
            StStart: w_state_d = StWait;
            StWait: begin
                if (mul_done) begin
                    w_state_d = StResp;
                end else if (w_tmo_hit) begin
                    w_timeout = 1'b1;
                    w_state_d = StResp;
                end
            end
            StResp:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Outputs are registered, decoded from the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr          <= '0;
            r_idx          <= '0;
            r_req_ack      <= '0;
            r_resp_valid   <= '0;
            r_resp_err     <= '0;
            r_resp_product <= '0;
            r_busy         <= 1'b0;
            r_mul_start    <= 1'b0;
            r_mul_a        <= '0;
            r_mul_b        <= '0;
        end else begin
            r_busy       <= (w_state_d != StIdle);
            r_mul_start  <= (w_state_d == StStart);
            r_req_ack    <= (w_state_d == StStart) ? w_sel_onehot : '0;
            r_resp_valid <= (w_state_d == StResp) ? w_idx_onehot : '0;
            r_resp_err   <= w_timeout ? w_idx_onehot : '0;
            if (w_grant) begin
                r_idx   <= w_sel;
                r_mul_a <= w_sel_a;
                r_mul_b <= w_sel_b;
            end
            if ((r_state == StWait) && (w_state_d == StResp)) begin
                r_resp_product <= w_timeout ? '0 : mul_product;
            end
            if (r_state == StResp) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    assign req_ack      = r_req_ack;
    assign resp_valid   = r_resp_valid;
    assign resp_err     = r_resp_err;
    assign resp_product = r_resp_product;
    assign busy         = r_busy;
    assign mul_start    = r_mul_start;
    assign mul_a        = r_mul_a;
    assign mul_b        = r_mul_b;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed self-checking bench for mul_arbiter with a fixed-latency multiplier stub.
// Timeout steps run only when MUL_ARB_TIMEOUT_EN is defined.
module tb_mul_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [63:0] req_a, req_b;
    logic [3:0]  req_ack, resp_valid, resp_err;
    logic [31:0] resp_product;
    logic        busy, mul_start;
    logic [15:0] mul_a, mul_b;
    logic [31:0] mul_product;
    logic        mul_done;

    logic        stub_en, extra_done, stub_done;
    logic [31:0] stub_prod;
    int unsigned stub_cnt;
    int unsigned lat;

    int checks = 0;
    int errors = 0;
    int n_resp;
    int n_wait;
    int q_size;

    logic [3:0]  ack_q[$];
    logic [3:0]  resp_q[$];
    logic [31:0] prod_q[$];

    mul_arbiter #(
        .WIDTH          (16),
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ack      (req_ack),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_product (resp_product),
        .busy         (busy),
        .mul_start    (mul_start),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_product  (mul_product),
        .mul_done     (mul_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier stub: done pulses lat edges after start is seen.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            stub_cnt  <= 0;
            stub_done <= 1'b0;
            stub_prod <= '0;
        end else begin
            stub_done <= 1'b0;
            if (mul_start && stub_en) begin
                stub_cnt <= lat;
            end else if (stub_cnt != 0) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1) begin
                    stub_done <= 1'b1;
                    stub_prod <= $signed(mul_a) * $signed(mul_b);
                end
            end
        end
    end

    assign mul_done    = stub_done | extra_done;
    assign mul_product = stub_prod;

    always @(negedge clk) begin
        if (!reset) begin
            if (req_ack != 0) ack_q.push_back(req_ack);
            if (resp_valid != 0) begin
                resp_q.push_back(resp_valid);
                prod_q.push_back(resp_product);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
        req_valid[i]      = 1'b1;
    endtask

    task automatic wait_ack(input string tag);
        for (int n = 0; n < 50; n++) begin
            step();
            if (req_ack != 0) break;
        end
        chk(tag, 64'(req_ack != 0), 64'd1);
    endtask

    task automatic wait_resp(input string tag);
        for (int n = 0; n < 50; n++) begin
            step();
            if (resp_valid != 0) break;
        end
        chk(tag, 64'(resp_valid != 0), 64'd1);
    endtask

    task automatic run_one(input string tag, input int i, input logic [15:0] a,
                           input logic [15:0] b, input logic [31:0] exp);
        set_req(i, a, b);
        wait_ack({tag, "_ackwait"});
        chk({tag, "_ack"}, req_ack, 4'b0001 << i);
        req_valid[i] = 1'b0;
        wait_resp({tag, "_respwait"});
        chk({tag, "_resp"}, resp_valid, 4'b0001 << i);
        chk({tag, "_err"}, resp_err, 4'b0000);
        chk({tag, "_prod"}, resp_product, exp);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        stub_en    = 1'b1;
        extra_done = 1'b0;
        lat        = 5;
        repeat (2) step();

        chk("rst_ctrl", {busy, mul_start, req_ack, resp_valid, resp_err}, 0);
        chk("rst_prod", resp_product, 0);
        chk("rst_ops", {mul_a, mul_b}, 0);
        reset = 1'b0;
        step();

        // Single request on requester 1
        set_req(1, 16'd201, 16'd102);
        wait_ack("single_ackwait");
        chk("single_ack", req_ack, 4'b0010);
        chk("single_start", {mul_start, busy}, 2'b11);
        chk("single_ops", {mul_a, mul_b}, {16'd201, 16'd102});
        req_valid[1] = 1'b0;
        step();
        chk("single_ack_pulse", {req_ack, mul_start}, 0);
        chk("single_ops_held", {mul_a, mul_b}, {16'd201, 16'd102});
        wait_resp("single_respwait");
        chk("single_resp", resp_valid, 4'b0010);
        chk("single_prod", resp_product, 32'd20502);
        step();
        chk("single_after", {resp_valid, busy}, 0);
        chk("single_prod_held", resp_product, 32'd20502);

        // Signed operands
        run_one("neg3x7", 0, 16'hFFFD, 16'd7, 32'hFFFFFFEB);
        run_one("minxmin", 0, 16'h8000, 16'h8000, 32'h40000000);

        // Contention from ptr 0
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        ack_q.delete();
        resp_q.delete();
        prod_q.delete();
        req_a     = {16'd1234, 16'd100, 16'hFFFC, 16'd3};
        req_b     = {16'd2, 16'hFF9C, 16'd6, 16'd5};
        req_valid = 4'b1111;
        n_resp    = 0;
        for (int n = 0; n < 200 && n_resp < 4; n++) begin
            step();
            if (req_ack != 0) req_valid = req_valid & ~req_ack;
            if (resp_valid != 0) n_resp++;
        end
        step();
        chk("cont_count", resp_q.size(), 4);
        chk("cont_acks", ack_q.size(), 4);
        chk("cont_g0", {ack_q[0], resp_q[0], prod_q[0]}, {4'b0001, 4'b0001, 32'd15});
        chk("cont_g1", {ack_q[1], resp_q[1], prod_q[1]}, {4'b0010, 4'b0010, 32'hFFFFFFE8});
        chk("cont_g2", {ack_q[2], resp_q[2], prod_q[2]}, {4'b0100, 4'b0100, 32'hFFFFD8F0});
        chk("cont_g3", {ack_q[3], resp_q[3], prod_q[3]}, {4'b1000, 4'b1000, 32'd2468});

        // Pointer back at 0: requester 0 beats 3
        req_valid = 4'b1001;
        wait_ack("ptr0_ackwait");
        chk("ptr0_ack", req_ack, 4'b0001);
        req_valid[0] = 1'b0;
        wait_resp("ptr0_respwait");
        wait_ack("ptr3_ackwait");
        chk("ptr3_ack", req_ack, 4'b1000);
        req_valid[3] = 1'b0;
        wait_resp("ptr3_respwait");
        step();

        // Fairness between 0 and 2 with immediate re-request
        ack_q.delete();
        req_a     = {16'd0, 16'hFFFF, 16'd0, 16'd2};
        req_b     = {16'd0, 16'hFFFF, 16'd0, 16'd3};
        req_valid = 4'b0101;
        n_resp    = 0;
        for (int n = 0; n < 400 && n_resp < 6; n++) begin
            step();
            if (req_ack != 0) req_valid = req_valid & ~req_ack;
            if (resp_valid != 0) begin
                n_resp++;
                if (n_resp < 6) req_valid = req_valid | resp_valid;
            end
        end
        req_valid = '0;
        repeat (2) step();
        chk("fair_count", ack_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("fair_grant%0d", i), ack_q[i], (i % 2 == 0) ? 4'b0001 : 4'b0100);
        end

        // Stray done while idle
        q_size     = resp_q.size();
        extra_done = 1'b1;
        step();
        extra_done = 1'b0;
        repeat (3) step();
        chk("idle_done_ignored", resp_q.size(), q_size);
        chk("idle_done_busy", busy, 1'b0);

`ifdef MUL_ARB_TIMEOUT_EN
        stub_en = 1'b0;
        set_req(0, 16'd5, 16'd5);
        wait_ack("tmo_ackwait");
        req_valid = '0;
        n_wait    = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            n_wait++;
            if (resp_valid != 0) break;
        end
        chk("tmo_latency", n_wait, 9);
        chk("tmo_resp", {resp_valid, resp_err}, {4'b0001, 4'b0001});
        chk("tmo_prod", resp_product, 0);
        step();
        q_size     = resp_q.size();
        extra_done = 1'b1;
        step();
        extra_done = 1'b0;
        repeat (3) step();
        chk("tmo_late_done", resp_q.size(), q_size);
        stub_en = 1'b1;
`endif

        // Reset three cycles into WAIT
        resp_q.delete();
        ack_q.delete();
        stub_en = 1'b0;
        set_req(1, 16'h0011, 16'h0002);
        wait_ack("abort_ackwait");
        chk("abort_ack", req_ack, 4'b0010);
        req_valid = '0;
        step();
        repeat (3) step();
        chk("abort_busy_pre", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_ctrl", {busy, mul_start, req_ack, resp_valid, resp_err}, 0);
        chk("abort_data", {resp_product, mul_a, mul_b}, 0);
        set_req(3, 16'd7, 16'hFFF8);
        repeat (2) step();
        reset   = 1'b0;
        stub_en = 1'b1;
        wait_ack("post_ackwait");
        chk("post_ack", req_ack, 4'b1000);
        req_valid = '0;
        wait_resp("post_respwait");
        chk("post_resp", resp_valid, 4'b1000);
        chk("post_prod", resp_product, 32'hFFFFFFC8);
        step();
        chk("abort_no_resp", resp_q.size(), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
